// File: rtl/nand_share_pkg.sv
// Shared types and constants for the NAND-sharing arbiter.
package nand_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned W_DEF     = 4;
   localparam int unsigned CNT_W_DEF = 8;

   // Requester-index width; never below one bit so ports stay legal.
   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nand_unit.sv
// Shared combinational NAND datapath, one instance per arbiter.
module nand_unit
   import nand_share_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = ~(a & b);

endmodule

// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter sequencing N_REQ requesters onto one NAND unit.
module nand_share_arbiter
   import nand_share_pkg::*;
#(
   parameter  int unsigned N_REQ = N_REQ_DEF,
   parameter  int unsigned W     = W_DEF,
   parameter  int unsigned CNT_W = CNT_W_DEF,
   localparam int unsigned ID_W  = id_width(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [W-1:0]       resp_y,
   output logic [ID_W-1:0]    resp_id,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   gid_q, gid_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;
   logic [W-1:0]      opa_q, opa_d;
   logic [W-1:0]      opb_q, opb_d;
   logic [W-1:0]      resp_y_q, resp_y_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic [ID_W:0]     pick;
   logic              pick_vld;
   logic [ID_W-1:0]   pick_id;
   logic [N_REQ-1:0]  grant_c;
   logic [W-1:0]      nand_y;

   // First valid requester at or after ptr, wrapping; returns {found, index}.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  ptr);
      logic [ID_W:0]   r;
      logic [ID_W-1:0] idx;
      r = '0;
      // Walk from farthest to nearest so the nearest valid bit wins.
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         idx = ptr + ID_W'(k);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   nand_unit #(.W(W)) u_nand (
      .a (opa_q),
      .b (opb_q),
      .y (nand_y)
   );

   // Round-robin search over the current request vector.
   always_comb begin
      pick     = rr_pick(req_valid, rr_ptr_q);
      pick_vld = pick[ID_W];
      pick_id  = pick[ID_W-1:0];
   end

   // Next-state, datapath capture and grant decode.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gid_d      = gid_q;
      resp_id_d  = resp_id_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      resp_y_d   = resp_y_q;
      op_count_d = op_count_q;
      grant_c    = '0;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_c[pick_id] = 1'b1;
               opa_d            = req_a[32'(pick_id) * W +: W];
               opb_d            = req_b[32'(pick_id) * W +: W];
               gid_d            = pick_id;
               state_d          = EXEC;
            end
         end
         EXEC: begin
            resp_y_d  = nand_y;
            resp_id_d = gid_q;
            state_d   = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               // Winner drops to lowest priority for the next search.
               rr_ptr_d   = gid_q + ID_W'(1);
               op_count_d = (&op_count_q) ? op_count_q : op_count_q + CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gid_q      <= '0;
         resp_id_q  <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         resp_y_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gid_q      <= gid_d;
         resp_id_q  <= resp_id_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         resp_y_q   <= resp_y_d;
         op_count_q <= op_count_d;
      end
   end

   // Grant is combinational so the handshake closes in the accept cycle;
   // it is forced low while reset is held.
   assign req_ready  = rst ? '0 : grant_c;
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_y     = resp_y_q;
   assign resp_id    = resp_id_q;
   assign op_count   = op_count_q;

endmodule

// File: doc/nand_share_arbiter.md
Name: nand_share_arbiter

Overview:
Shares one NAND datapath between N_REQ requesters. Each requester hands over an operand pair through a valid/ready handshake. The arbiter picks one winner per operation with a round-robin policy, sequences the shared NAND unit, and returns the result tagged with the winner's index. It sits between the tile's pin-level input decode and a single instance of the NAND datapath cell.

Parameters:
N_REQ, 4, number of requesters; power of two, 2..8
W, 4, operand/result width in bits; NAND is applied bitwise
CNT_W, 8, width of the saturating completed-operation counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset; top level drives rst = ~rst_n
req_valid  input  N_REQ  per-requester request valid
req_a  input  N_REQ*W  operand A, requester i in bits [i*W +: W]
req_b  input  N_REQ*W  operand B, same packing as req_a
req_ready  output  N_REQ  one-hot accept strobe; never more than one bit set
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts the result
resp_y  output  W  result, ~(a & b) bitwise
resp_id  output  $clog2(N_REQ)  index of the requester that owns resp_y
busy  output  1  high when state is not IDLE
op_count  output  CNT_W  completed responses, saturating

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=0 (requester 0 has highest priority).
  - resp_valid=0, resp_y=0, resp_id=0, busy=0, op_count=0, req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at rr_ptr and wrapping modulo N_REQ. First set bit wins (index g).
  - req_ready[g]=1 combinationally in that same cycle. The handshake completes that cycle.
  - Latch req_a[g], req_b[g] and g into operand registers; go to EXEC.
  - No valid requests: stay in IDLE; req_ready=0.
- EXEC (1 cycle):
  - Latched operands drive the shared NAND unit.
  - Register its output into resp_y and g into resp_id; go to RESP.
- RESP:
  - resp_valid=1; resp_y and resp_id stay stable until resp_ready.
  - On resp_valid & resp_ready: rr_ptr=(g+1) mod N_REQ; op_count+=1, saturating at 2^CNT_W-1; go to IDLE.
  - resp_ready low: hold RESP indefinitely. All req_ready stay 0.
- Latency and throughput:
  - Accept at cycle T, resp_valid rises at T+2.
  - Minimum 3 cycles per operation when resp_ready is held high.
- req_ready is 0 in EXEC and RESP, regardless of req_valid.
- Requesters hold valid and operands stable until ready. req_valid is sampled only in IDLE, so a drop before acceptance simply loses arbitration.
- Simultaneous requests from all requesters, with resp_ready=1: grants go 0,1,2,3,0,… No requester waits more than N_REQ-1 grants.
- A requester that re-asserts right after its grant goes last in priority.
- rr_ptr updates only on response completion, not on accept.
- Reset mid-operation: the in-flight result is discarded; resp_valid drops immediately (async); state=IDLE, rr_ptr=0.
- No X on outputs while rst is deasserted. Unused upper bits of resp_id do not exist, because the width is exactly $clog2(N_REQ).

Decomposition:
- Shared package nand_share_pkg holds:
  - the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the default N_REQ/W constants;
  - the clog2-derived ID width function.
- One sub-module, nand_unit:
  - purely combinational, bitwise W-wide y = ~(a & b);
  - the shared datapath instance, one per arbiter.
- The round-robin priority search stays in the arbiter as a function; it is not a separate module.

Test Plan:
1. Reset, then req_valid=4'b0100, a=4'hF, b=4'hA on requester 2 -> req_ready=4'b0100 for exactly 1 cycle; 2 cycles later resp_valid=1, resp_y=4'h5, resp_id=2; op_count=1 after resp_ready.
2. All four valid continuously, resp_ready=1, operand pair for requester i = (i, 4'hF) -> resp_id sequence 0,1,2,3,0; resp_y = ~i & 4'hF = F,E,D,C,F; one response every 3 cycles.
3. resp_ready held 0 for 10 cycles in RESP with new requests pending -> resp_y/resp_id stable, req_ready=0 throughout; release -> next grant goes to (previous id+1).
4. Assert rst during EXEC -> resp_valid, busy, op_count, req_ready all 0 in the same cycle; after release, requester 0 wins over requester 3 when both are valid.
5. CNT_W=2, 5 completed ops -> op_count reads 1,2,3,3,3.
6. Exhaustive W=4 operand sweep via requester 1 (256 pairs) -> every resp_y equals ~(a&b); no X on any output.
